// File: rtl/mem_rw_responder_if.sv
// Request/response bundle between a memory requester and the RAM responder.
// The requester drives the request fields; the responder drives ack and the read/write status.
interface mem_rw_responder_if;
  logic        request;
  logic [29:0] addr;
  logic        rnw;
  logic [4:0]  rlen;
  logic [3:0]  wbe;
  logic [31:0] wdata;
  logic        rmw;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;
  logic        write_outstanding;

  modport master (
    output request, addr, rnw, rlen, wbe, wdata, rmw,
    input  ack, rvalid, rdata, write_outstanding
  );

  modport slave (
    input  request, addr, rnw, rlen, wbe, wdata, rmw,
    output ack, rvalid, rdata, write_outstanding
  );
endinterface

// File: rtl/mem_rw_responder.sv
// Serialized read/write responder backed by a word-addressed RAM.
// Supports single reads, line-aligned burst reads and byte-enabled writes.
module mem_rw_responder #(
  parameter int DEPTH_W       = 12,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input logic            clk,
  input logic            rst,
  mem_rw_responder_if.slave bus
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] READ_WAIT    = 2'd1;
  localparam logic [1:0] READ_BURST   = 2'd2;
  localparam logic [1:0] WRITE_COMMIT = 2'd3;

  logic [1:0]         state;
  logic [3:0]         lat_cnt;
  logic [4:0]         beat_cnt;
  logic [DEPTH_W-1:0] req_base;
  logic [DEPTH_W-1:0] rd_addr;
  logic               commit;

  logic [DEPTH_W-1:0] addr_p0;
  logic [4:0]         rlen_p0;
  logic [3:0]         wbe_p0;
  logic [31:0]        wdata_p0;
  logic [31:0]        rdata_p1;

  logic [31:0] ram [2**DEPTH_W];

  // Upper address bits alias onto the RAM; rmw is accepted but has no effect.
  logic unused_bits;
  assign unused_bits = ^{bus.rmw, bus.addr[29:DEPTH_W]};

  assign bus.ack               = bus.request && (state == IDLE);
  assign bus.rvalid            = (state == READ_BURST);
  assign bus.rdata             = rdata_p1;
  assign bus.write_outstanding = (state == WRITE_COMMIT);

  assign req_base = bus.addr[DEPTH_W-1:0] & ~DEPTH_W'(bus.rlen);
  assign commit   = (state == WRITE_COMMIT) && (lat_cnt == 4'd1);

  // Address presented one cycle ahead of each beat (synchronous RAM read).
  always_comb begin
    rd_addr = addr_p0;
    if (state == IDLE)
      rd_addr = req_base;
    else if (state == READ_BURST)
      rd_addr = addr_p0 + DEPTH_W'(beat_cnt) + DEPTH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ack) begin
            if (bus.rnw) begin
              beat_cnt <= '0;
              if (READ_LATENCY == 1) begin
                state <= READ_BURST;
              end else begin
                state   <= READ_WAIT;
                lat_cnt <= 4'(READ_LATENCY - 1);
              end
            end else begin
              state   <= WRITE_COMMIT;
              lat_cnt <= 4'(WRITE_LATENCY);
            end
          end
        end
        READ_WAIT: begin
          if (lat_cnt == 4'd1) state <= READ_BURST;
          else                 lat_cnt <= lat_cnt - 4'd1;
        end
        READ_BURST: begin
          if (beat_cnt == rlen_p0) state <= IDLE;
          else                     beat_cnt <= beat_cnt + 5'd1;
        end
        WRITE_COMMIT: begin
          if (lat_cnt == 4'd1) state <= IDLE;
          else                 lat_cnt <= lat_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: request fields captured on the ack edge; reads keep the aligned base.
  always_ff @(posedge clk) begin
    if (bus.ack) begin
      addr_p0  <= bus.rnw ? req_base : bus.addr[DEPTH_W-1:0];
      rlen_p0  <= bus.rlen;
      wbe_p0   <= bus.wbe;
      wdata_p0 <= bus.wdata;
    end
  end

  // Stage p1: registered RAM read data; commit is suppressed by a coincident reset.
  always_ff @(posedge clk) begin
    rdata_p1 <= ram[rd_addr];
    if (commit && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe_p0[b]) ram[addr_p0][b*8 +: 8] <= wdata_p0[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_rw_responder.sv
// Bench for mem_rw_responder: two instances (different latencies) checked against a word-array model.
module tb_mem_rw_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          sel = 1'b0;
  logic        req_d = 1'b0;
  logic [29:0] addr_d = '0;
  logic        rnw_d = 1'b0;
  logic [4:0]  rlen_d = '0;
  logic [3:0]  wbe_d = '0;
  logic [31:0] wdata_d = '0;
  logic        rmw_d = 1'b0;

  logic        ack_m, rvalid_m, wo_m;
  logic [31:0] rdata_m;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_m [2][256];

  mem_rw_responder_if ifa ();
  mem_rw_responder_if ifb ();

  assign ifa.request = req_d & ~sel;
  assign ifb.request = req_d & sel;
  assign ifa.addr  = addr_d;  assign ifb.addr  = addr_d;
  assign ifa.rnw   = rnw_d;   assign ifb.rnw   = rnw_d;
  assign ifa.rlen  = rlen_d;  assign ifb.rlen  = rlen_d;
  assign ifa.wbe   = wbe_d;   assign ifb.wbe   = wbe_d;
  assign ifa.wdata = wdata_d; assign ifb.wdata = wdata_d;
  assign ifa.rmw   = rmw_d;   assign ifb.rmw   = rmw_d;

  assign ack_m    = sel ? ifb.ack : ifa.ack;
  assign rvalid_m = sel ? ifb.rvalid : ifa.rvalid;
  assign rdata_m  = sel ? ifb.rdata : ifa.rdata;
  assign wo_m     = sel ? ifb.write_outstanding : ifa.write_outstanding;

  mem_rw_responder #(.DEPTH_W(8), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  mem_rw_responder #(.DEPTH_W(8), .READ_LATENCY(3), .WRITE_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  always #5 clk = ~clk;

  function automatic int rl_f();
    return sel ? 3 : 2;
  endfunction

  function automatic int wl_f();
    return sel ? 3 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (dut %0d): observed %h expected %h", tag, sel, obs, exp);
    end
  endtask

  // Raise a request and wait for its ack; returns in the cycle after ack, at posedge+1.
  task automatic issue(input logic r, input logic [29:0] a, input logic [4:0] len,
                       input logic [3:0] be, input logic [31:0] d, input bit hold,
                       output int waited);
    rnw_d = r; addr_d = a; rlen_d = len; wbe_d = be; wdata_d = d;
    rmw_d = 1'($urandom); req_d = 1'b1; waited = 0;
    while (1) begin
      @(negedge clk);
      if (ack_m) break;
      waited++;
      if (waited > 100) break;
      @(posedge clk); #1;
    end
    check("ack_bound", 32'(waited > 100), 32'd0);
    @(posedge clk); #1;
    if (!hold) req_d = 1'b0;
  endtask

  // Cycle c counts from the cycle after ack (c=1). rst_c>0 asserts rst in that cycle.
  task automatic check_read(input logic [29:0] a, input logic [4:0] len, input bit hold,
                            input int rst_c);
    int rl, cmax;
    bit exp_v;
    logic [7:0] base;
    rl   = rl_f();
    base = a[7:0] & ~{3'b000, len};
    cmax = (rst_c != 0) ? rst_c + 1 : rl + int'(len) + 1;
    for (int c = 1; c <= cmax; c++) begin
      rst = (c == rst_c);
      @(negedge clk);
      exp_v = (c >= rl) && (c <= rl + int'(len)) && !(rst_c != 0 && c > rst_c);
      check("rvalid", 32'(rvalid_m), 32'(exp_v));
      if (exp_v) check("rdata", rdata_m, mem_m[sel][8'(int'(base) + c - rl)]);
      if (hold) check("ack_held", 32'(ack_m), 32'(c == rl + int'(len) + 1));
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic check_write(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d,
                             input bit chain, input int rst_c);
    int wl;
    bit exp_wo;
    wl = wl_f();
    for (int c = 1; c <= wl + 1; c++) begin
      rst = (c == rst_c);
      @(negedge clk);
      exp_wo = (c <= wl) && (rst_c == 0 || c <= rst_c);
      check("write_outstanding", 32'(wo_m), 32'(exp_wo));
      if (chain) check("ack_after_write", 32'(ack_m), 32'(c == wl + 1));
      @(posedge clk); #1;
    end
    rst = 1'b0;
    if (rst_c == 0) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_m[sel][a[7:0]][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic do_write(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    int w;
    issue(1'b0, a, 5'd0, be, d, 1'b0, w);
    check_write(a, be, d, 1'b0, 0);
  endtask

  task automatic do_read(input logic [29:0] a, input logic [4:0] len);
    int w;
    issue(1'b1, a, len, 4'h0, 32'h0, 1'b0, w);
    check_read(a, len, 1'b0, 0);
  endtask

  initial begin
    int w;
    logic [31:0] d;
    logic [29:0] a;
    logic [4:0]  len;

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      @(negedge clk);
      check("rst_ack", 32'(ack_m), 32'd0);
      check("rst_rvalid", 32'(rvalid_m), 32'd0);
      check("rst_write_outstanding", 32'(wo_m), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);

      // Preload every word through aliased addresses
      for (int i = 0; i < 256; i++)
        do_write({22'($urandom), 8'(i)}, 4'hF, $urandom);

      // Single read with request held: second ack exactly RL+1 cycles after the first
      do_write(30'h10, 4'hF, 32'hDEADBEEF);
      issue(1'b1, 30'h10, 5'd0, 4'h0, 32'h0, 1'b1, w);
      check_read(30'h10, 5'd0, 1'b1, 0);
      req_d = 1'b0;
      check_read(30'h10, 5'd0, 1'b0, 0);

      // Aligned 8-beat burst, request held through it
      for (int i = 0; i < 8; i++) do_write(30'h40 + 30'(i), 4'hF, 32'(i));
      issue(1'b1, 30'h45, 5'd7, 4'h0, 32'h0, 1'b1, w);
      check_read(30'h45, 5'd7, 1'b1, 0);
      req_d = 1'b0;
      check_read(30'h45, 5'd7, 1'b0, 0);

      // Byte-enabled write, then a no-op write
      do_write(30'h20, 4'hF, 32'h11223344);
      do_write(30'h20, 4'b0101, 32'hAABBCCDD);
      do_read(30'h20, 5'd0);
      do_write(30'h20, 4'h0, $urandom);
      do_read(30'h20, 5'd0);

      // Write immediately followed by read of the same word, request held
      d = $urandom;
      issue(1'b0, 30'h30, 5'd0, 4'hF, d, 1'b1, w);
      rnw_d = 1'b1;
      rlen_d = 5'd0;
      check_write(30'h30, 4'hF, d, 1'b1, 0);
      req_d = 1'b0;
      check_read(30'h30, 5'd0, 1'b0, 0);

      // Reset on beat 3 of a burst, then immediate ack
      issue(1'b1, 30'h45, 5'd7, 4'h0, 32'h0, 1'b0, w);
      check_read(30'h45, 5'd7, 1'b0, rl_f() + 3);
      issue(1'b1, 30'h10, 5'd0, 4'h0, 32'h0, 1'b0, w);
      check("ack_wait_after_rst", 32'(w), 32'd0);
      check_read(30'h10, 5'd0, 1'b0, 0);

      // Reset sampled on the commit edge discards the write
      d = $urandom;
      issue(1'b0, 30'h20, 5'd0, 4'hF, d, 1'b0, w);
      check_write(30'h20, 4'hF, d, 1'b0, wl_f());
      do_read(30'h20, 5'd0);

      // Random mix of reads, bursts and writes
      for (int k = 0; k < 60; k++) begin
        a = 30'($urandom);
        if ($urandom_range(1, 0) == 1) begin
          len = 5'((1 << $urandom_range(5, 0)) - 1);
          do_read(a, len);
        end else begin
          do_write(a, 4'($urandom), $urandom);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
